// File: rtl/sram_seq_streamer_if.sv
// Command, write-stream, read-stream and SRAM port bundle for sram_seq_streamer.
// The streamer takes the slave view; the client/SRAM environment takes the master view.
interface sram_seq_streamer_if #(
  parameter int p_addr_nbits = 8,
  parameter int p_data_nbits = 32
);
  logic                        cmd_val;
  logic                        cmd_rdy;
  logic                        cmd_op;
  logic [p_addr_nbits-1:0]     cmd_base;
  logic [p_addr_nbits:0]       cmd_len;

  logic                        wr_val;
  logic                        wr_rdy;
  logic [p_data_nbits-1:0]     wr_data;

  logic                        rd_val;
  logic                        rd_rdy;
  logic [p_data_nbits-1:0]     rd_data;

  logic                        done;

  logic                        sram_csb;
  logic                        sram_web;
  logic [p_data_nbits/8-1:0]   sram_wmask;
  logic [p_addr_nbits-1:0]     sram_addr;
  logic [p_data_nbits-1:0]     sram_din;
  logic [p_data_nbits-1:0]     sram_dout;

  modport master (
    output cmd_val, cmd_op, cmd_base, cmd_len, wr_val, wr_data, rd_rdy, sram_dout,
    input  cmd_rdy, wr_rdy, rd_val, rd_data, done,
    input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din
  );

  modport slave (
    input  cmd_val, cmd_op, cmd_base, cmd_len, wr_val, wr_data, rd_rdy, sram_dout,
    output cmd_rdy, wr_rdy, rd_val, rd_data, done,
    output sram_csb, sram_web, sram_wmask, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_seq_streamer.sv
// Sequential streamer for the single-port sequence SRAM: writes a val/rdy stream into
// consecutive words, or reads consecutive words out through a 3-entry buffer.
module sram_seq_streamer #(
  parameter int p_addr_nbits = 8,
  parameter int p_data_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  sram_seq_streamer_if.slave bus
);
  localparam int LEN_W  = p_addr_nbits + 1;
  localparam int MASK_W = p_data_nbits / 8;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << p_addr_nbits);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                  state_q, state_d;
  logic [p_addr_nbits-1:0] addr_q;
  logic [LEN_W-1:0]        rem_q;
  logic                    vld_p1;
  logic [p_data_nbits-1:0] fifo_mem [0:2];
  logic [1:0]              wr_ptr_q, rd_ptr_q, count_q, count_d;

  logic accept, beat, issue, push, pop, room;

  logic                    cmd_rdy, wr_rdy, rd_val, done;
  logic [p_data_nbits-1:0] rd_data;
  logic                    csb, web;
  logic [MASK_W-1:0]       wmask;
  logic [p_addr_nbits-1:0] addr;
  logic [p_data_nbits-1:0] din;

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    cmd_rdy = 1'b0;
    wr_rdy  = 1'b0;
    done    = 1'b0;
    csb     = 1'b1;
    web     = 1'b1;
    wmask   = '0;
    addr    = '0;
    din     = '0;
    accept  = 1'b0;
    beat    = 1'b0;
    issue   = 1'b0;

    // Buffer occupancy counts the word still in flight from the SRAM.
    room    = ({1'b0, count_q} + {2'b00, vld_p1}) < 3'd3;
    push    = vld_p1;
    rd_val  = !reset && (count_q != 2'd0);
    pop     = rd_val && bus.rd_rdy;
    rd_data = rd_val ? fifo_mem[rd_ptr_q] : '0;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          cmd_rdy = 1'b1;
          accept  = bus.cmd_val;
          if (accept) begin
            if (sat_len(bus.cmd_len) == '0) state_d = DONE;
            else if (bus.cmd_op)            state_d = WRITE;
            else                            state_d = READ;
          end
        end
        WRITE: begin
          wr_rdy = 1'b1;
          beat   = bus.wr_val;
          if (beat) begin
            csb   = 1'b0;
            web   = 1'b0;
            wmask = '1;
            addr  = addr_q;
            din   = bus.wr_data;
            if (rem_q == LEN_W'(1)) state_d = DONE;
          end
        end
        READ: begin
          issue = (rem_q != '0) && room;
          if (issue) begin
            csb  = 1'b0;
            addr = addr_q;
          end
          // Finish in the same cycle the final word leaves the buffer.
          if (rem_q == '0 && !vld_p1 && count_d == 2'd0) state_d = DONE;
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      vld_p1   <= 1'b0;
      count_q  <= 2'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= bus.cmd_base;
        rem_q  <= sat_len(bus.cmd_len);
      end else if (beat || issue) begin
        addr_q <= addr_q + p_addr_nbits'(1);
        rem_q  <= rem_q - LEN_W'(1);
      end
      // p0 -> p1: read issued this cycle, sram_dout valid next cycle
      vld_p1  <= issue;
      count_q <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // p1 -> buffer: capture the word returned by the SRAM
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.sram_dout;
  end

  assign bus.cmd_rdy    = cmd_rdy;
  assign bus.wr_rdy     = wr_rdy;
  assign bus.rd_val     = rd_val;
  assign bus.rd_data    = rd_data;
  assign bus.done       = done;
  assign bus.sram_csb   = csb;
  assign bus.sram_web   = web;
  assign bus.sram_wmask = wmask;
  assign bus.sram_addr  = addr;
  assign bus.sram_din   = din;
endmodule

// File: doc/sram_seq_streamer.md
# sram_seq_streamer

Sequential stream port for the 32x256 single-port sequence SRAM of the Blastn datapath. Accepts a command (base address, length, read or write) and either writes a val/rdy input stream into consecutive SRAM words or reads consecutive words out as a val/rdy output stream. It hides the SRAM's one-cycle read latency behind a 3-entry output buffer, and is the only master of the SRAM port.

## Interface
- p_addr_nbits, 8, SRAM word-address width (256 entries)
- p_data_nbits, 32, SRAM word width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_val  input  1  command valid
- cmd_rdy  output  1  command accepted when cmd_val && cmd_rdy
- cmd_op  input  1  0 = read, 1 = write
- cmd_base  input  8  first word address
- cmd_len  input  9  word count, 0..256; values above 256 saturate to 256
- wr_val  input  1  write-stream beat valid
- wr_rdy  output  1  write-stream ready
- wr_data  input  32  write-stream word
- rd_val  output  1  read-stream word valid
- rd_rdy  input  1  read-stream consumer ready
- rd_data  output  32  read-stream word
- done  output  1  one-cycle pulse on command completion
- sram_csb  output  1  SRAM chip select, active low
- sram_web  output  1  SRAM write enable, active low
- sram_wmask  output  4  SRAM byte mask
- sram_addr  output  8  SRAM address
- sram_din  output  32  SRAM write data
- sram_dout  input  32  SRAM read data

## Operation
- SRAM contract: on a rising edge with csb=0, web=0 writes din to addr under wmask. With csb=0 and web=1 it reads addr, and dout is valid in the following cycle.
- States: IDLE, WRITE, READ, DONE.
- IDLE: cmd_rdy=1. On accept, latch base into addr_q and the saturated len into rem_q.
  - len=0: go to DONE.
  - Otherwise go to WRITE (op=1) or READ (op=0).
- WRITE:
  - wr_rdy=1.
  - On each wr_val, drive csb=0, web=0, wmask=4'hF, addr=addr_q, din=wr_data in that same cycle (combinational pass-through).
  - Per beat: addr_q+1 (mod 256) and rem_q-1. After the last beat, go to DONE.
- READ:
  - Issue a read (csb=0, web=1, addr=addr_q) when rem_q!=0 and fifo_count + inflight < 3. inflight is a 1-bit register set on issue.
  - Per issue: addr_q+1 (mod 256) and rem_q-1.
  - When inflight=1, push sram_dout into the 3-entry FIFO.
  - rd_val = FIFO not empty; rd_data = FIFO head; pop on rd_val && rd_rdy.
  - Go to DONE when rem_q=0, inflight=0 and the FIFO is empty.
- DONE: done=1 for one cycle, then IDLE. cmd_rdy=0 in DONE.
- Address wrap: base+len beyond 255 wraps to 0 and continues.
- No combinational path from rd_rdy or cmd_val to any sram_* output. The only combinational path to the SRAM is wr_val/wr_data to sram_csb/web/din.
- When not accessing the SRAM: csb=1, web=1, wmask=0, addr=0, din=0.
- Reset (at any time, including mid-command): return to IDLE, clear the FIFO, inflight, addr_q and rem_q. No done pulse for the aborted command.

## Timing
- Outputs while reset is high: cmd_rdy=0, wr_rdy=0, rd_val=0, rd_data=0, done=0, sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
- First cycle after reset deasserts: cmd_rdy=1.
- Command accepted in cycle t:
  - First SRAM access is no earlier than t+1.
  - len=0: done at t+1; cmd_rdy=1 at t+2.
- Write:
  - One word per cycle while wr_val=1.
  - done pulses the cycle after the last beat is accepted.
- Read:
  - First read issue at t+1, data captured at t+2, rd_val=1 at t+3.
  - With rd_rdy held high, one word per cycle sustained.
  - done pulses the cycle after the last rd handshake.
- Back-to-back commands: the next cmd can be accepted in the cycle after done, i.e. one command per (N + overhead) cycles.

## Test plan
- Write base=0x10, len=4, words 0xA0..0xA3 with wr_val held high -> SRAM writes at 0x10..0x13, one per cycle; done one cycle after the 4th beat. Then read base=0x10, len=4 -> rd_data 0xA0..0xA3 in order; first rd_val at t+3.
- Read len=256 with rd_rdy=1 -> 256 words on 256 consecutive rd_val cycles; done the cycle after the last handshake.
- Read len=8 with rd_rdy toggling 1,0,0,1 -> no word lost or duplicated; SRAM issue stalls when FIFO + inflight = 3; order preserved.
- Wrap: write base=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01. Then cmd_len=300 -> treated as 256 words.
- Edge commands: len=0 -> done at t+1 with no SRAM access (csb stays 1).
- Reset mid-read after 3 of 8 words -> next cycle rd_val=0, csb=1, no done pulse; cmd_rdy=1 after reset deasserts.
